// File: rtl/ex_mem_if.sv
// ex_mem_if: bundle of the EX-side, MEM-side, CP0 and bypass signals around
// the EX/MEM stage register.
//
// Handshake rules, used on both sides:
//   A transfer happens on a rising edge where valid and ready are both high.
//   A producer holds valid and its payload stable until that transfer.
//   ready may depend on the consumer's state but never on valid.
//   EX is the producer toward the stage (ex_valid/ex_ready).
//   The stage is the producer toward MEM (mem_valid/mem_ready).
interface ex_mem_if;
  // CP0 redirect
  logic        flush;
  // EX -> stage
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_alu_res;
  logic        ex_alu_ov;
  logic        ex_ov_chk;
  logic [31:0] ex_pc;
  logic [4:0]  ex_wreg;
  logic        ex_wen;
  logic [3:0]  ex_mem_op;
  logic [31:0] ex_store_data;
  // stage -> MEM
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_alu_res;
  logic [31:0] mem_pc;
  logic [4:0]  mem_wreg;
  logic        mem_wen;
  logic [3:0]  mem_mem_op;
  logic [31:0] mem_store_data;
  // stage <-> CP0
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_epc;
  logic        exc_ack;
  // bypass toward EX operand muxes
  logic        fwd_valid;
  logic [4:0]  fwd_reg;
  logic [31:0] fwd_data;

  // Environment side: EX, MEM and CP0 drive the inputs of the stage.
  modport master (
    output flush, ex_valid, ex_alu_res, ex_alu_ov, ex_ov_chk, ex_pc,
           ex_wreg, ex_wen, ex_mem_op, ex_store_data, mem_ready, exc_ack,
    input  ex_ready, mem_valid, mem_alu_res, mem_pc, mem_wreg, mem_wen,
           mem_mem_op, mem_store_data, exc_valid, exc_code, exc_epc,
           fwd_valid, fwd_reg, fwd_data
  );

  // Stage side.
  modport slave (
    input  flush, ex_valid, ex_alu_res, ex_alu_ov, ex_ov_chk, ex_pc,
           ex_wreg, ex_wen, ex_mem_op, ex_store_data, mem_ready, exc_ack,
    output ex_ready, mem_valid, mem_alu_res, mem_pc, mem_wreg, mem_wen,
           mem_mem_op, mem_store_data, exc_valid, exc_code, exc_epc,
           fwd_valid, fwd_reg, fwd_data
  );
endinterface

// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX/MEM pipeline register. Holds one executed instruction for
// MEM, converts a trapping overflow into a precise Ov exception for CP0 and
// drives the EX bypass from the held entry.
//
// Build option: define EX_MEM_SKID_EN to add a skid entry behind the head and
// register ex_ready, cutting the combinational mem_ready -> ex_ready path.
module ex_mem_reg #(
  parameter logic [4:0] EXC_OV = 5'h0C
) (
  input  logic       clk,
  input  logic       reset,
  ex_mem_if.slave    bus,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_EXC   = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] pc;
    logic [4:0]  wreg;
    logic        wen;
    logic [3:0]  mem_op;
    logic [31:0] store_data;
  } entry_t;

  state_t state_q, state_d;
  entry_t head_q, head_d;
  entry_t in_entry;
  logic   in_exc;
  logic   take_in, take_out;
  logic   ex_ready;

`ifdef EX_MEM_SKID_EN
  entry_t skid_q, skid_d;
  logic   skid_v_q, skid_v_d;
  logic   skid_exc_q, skid_exc_d;
  logic   ex_ready_q, ex_ready_d;
`endif

  // Capture the offered instruction; a trapping overflow must not write back
  // or touch memory, so its side effects are stripped at capture.
  always_comb begin
    in_exc              = bus.ex_alu_ov & bus.ex_ov_chk;
    in_entry.alu_res    = bus.ex_alu_res;
    in_entry.pc         = bus.ex_pc;
    in_entry.wreg       = bus.ex_wreg;
    in_entry.wen        = bus.ex_wen & ~in_exc;
    in_entry.mem_op     = in_exc ? 4'd0 : bus.ex_mem_op;
    in_entry.store_data = bus.ex_store_data;
  end

  assign take_in  = bus.ex_valid & ex_ready;
  assign take_out = (state_q == ST_FULL) & bus.mem_ready;

  // State register: async reset discards everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
`ifdef EX_MEM_SKID_EN
      skid_q     <= '0;
      skid_v_q   <= 1'b0;
      skid_exc_q <= 1'b0;
      ex_ready_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
`ifdef EX_MEM_SKID_EN
      skid_q     <= skid_d;
      skid_v_q   <= skid_v_d;
      skid_exc_q <= skid_exc_d;
      ex_ready_q <= ex_ready_d;
`endif
    end
  end

  // Next-state logic; flush wins over every other event in the cycle.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
`ifdef EX_MEM_SKID_EN
    skid_d     = skid_q;
    skid_v_d   = skid_v_q;
    skid_exc_d = skid_exc_q;
`endif
    if (bus.flush) begin
      state_d = ST_EMPTY;
`ifdef EX_MEM_SKID_EN
      skid_v_d   = 1'b0;
      skid_exc_d = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (take_in) begin
            head_d  = in_entry;
            state_d = in_exc ? ST_EXC : ST_FULL;
          end
        end
        ST_FULL: begin
`ifdef EX_MEM_SKID_EN
          if (take_out) begin
            if (skid_v_q) begin
              // Skid entry advances; its exception is raised only at the head.
              head_d     = skid_q;
              state_d    = skid_exc_q ? ST_EXC : ST_FULL;
              skid_v_d   = 1'b0;
              skid_exc_d = 1'b0;
            end else if (take_in) begin
              head_d  = in_entry;
              state_d = in_exc ? ST_EXC : ST_FULL;
            end else begin
              state_d = ST_EMPTY;
            end
          end else if (take_in) begin
            skid_d     = in_entry;
            skid_v_d   = 1'b1;
            skid_exc_d = in_exc;
          end
`else
          // Without a skid entry a transfer in implies a transfer out.
          if (take_in) begin
            head_d  = in_entry;
            state_d = in_exc ? ST_EXC : ST_FULL;
          end else if (take_out) begin
            state_d = ST_EMPTY;
          end
`endif
        end
        ST_EXC: begin
          if (bus.exc_ack) state_d = ST_EMPTY;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
`ifdef EX_MEM_SKID_EN
    // Accept only into a free skid slot and never behind a pending exception.
    ex_ready_d = ~skid_v_d & (state_d != ST_EXC);
`endif
  end

  // Output decode: everything comes from flops except ex_ready (unregistered
  // build) and the bypass qualification.
  always_comb begin
`ifdef EX_MEM_SKID_EN
    ex_ready = ex_ready_q;
`else
    ex_ready = (state_q == ST_EMPTY) | ((state_q == ST_FULL) & bus.mem_ready);
`endif
    bus.mem_valid      = (state_q == ST_FULL);
    bus.mem_alu_res    = head_q.alu_res;
    bus.mem_pc         = head_q.pc;
    bus.mem_wreg       = head_q.wreg;
    bus.mem_wen        = head_q.wen;
    bus.mem_mem_op     = head_q.mem_op;
    bus.mem_store_data = head_q.store_data;
    bus.exc_valid      = (state_q == ST_EXC);
    bus.exc_code       = (state_q == ST_EXC) ? EXC_OV : 5'd0;
    bus.exc_epc        = head_q.pc;
    // Loads are excluded: their alu_res is an address, not the write value.
    bus.fwd_valid      = (state_q == ST_FULL) & head_q.wen &
                         (head_q.mem_op == 4'd0) & (head_q.wreg != 5'd0);
    bus.fwd_reg        = head_q.wreg;
    bus.fwd_data       = head_q.alu_res;
  end

  assign bus.ex_ready = ex_ready;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
module tb_ex_mem_reg;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;

  ex_mem_if bus ();

  ex_mem_reg #(.EXC_OV(5'h0C)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // One cycle: inputs applied, ex_ready expected before the edge, outputs
  // expected after the edge.
  typedef struct {
    logic        v;
    logic [31:0] res;
    logic        ov;
    logic        chk;
    logic [31:0] pc;
    logic [4:0]  wreg;
    logic        wen;
    logic [3:0]  op;
    logic [31:0] sd;
    logic        mr;
    logic        ack;
    logic        fl;
    logic        e_rdy;
    logic        e_mv;
    logic [31:0] e_res;
    logic [31:0] e_pc;
    logic [4:0]  e_wreg;
    logic        e_wen;
    logic [3:0]  e_op;
    logic [31:0] e_sd;
    logic        e_xv;
    logic        e_fv;
  } vec_t;

  localparam int NV = 21;
  vec_t tv [NV];

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input vec_t t);
    bus.ex_valid      = t.v;
    bus.ex_alu_res    = t.res;
    bus.ex_alu_ov     = t.ov;
    bus.ex_ov_chk     = t.chk;
    bus.ex_pc         = t.pc;
    bus.ex_wreg       = t.wreg;
    bus.ex_wen        = t.wen;
    bus.ex_mem_op     = t.op;
    bus.ex_store_data = t.sd;
    bus.mem_ready     = t.mr;
    bus.exc_ack       = t.ack;
    bus.flush         = t.fl;
  endtask

  task automatic idle_inputs();
    bus.ex_valid      = 1'b0;
    bus.ex_alu_res    = '0;
    bus.ex_alu_ov     = 1'b0;
    bus.ex_ov_chk     = 1'b0;
    bus.ex_pc         = '0;
    bus.ex_wreg       = '0;
    bus.ex_wen        = 1'b0;
    bus.ex_mem_op     = '0;
    bus.ex_store_data = '0;
    bus.mem_ready     = 1'b0;
    bus.exc_ack       = 1'b0;
    bus.flush         = 1'b0;
  endtask

  task automatic check_outputs(input int i, input vec_t t);
    chk($sformatf("v%0d mem_valid", i), 32'(bus.mem_valid), 32'(t.e_mv));
    chk($sformatf("v%0d exc_valid", i), 32'(bus.exc_valid), 32'(t.e_xv));
    chk($sformatf("v%0d exc_code", i), 32'(bus.exc_code), t.e_xv ? 32'h0C : 32'h0);
    chk($sformatf("v%0d fwd_valid", i), 32'(bus.fwd_valid), 32'(t.e_fv));
    if (t.e_mv) begin
      chk($sformatf("v%0d mem_alu_res", i), bus.mem_alu_res, t.e_res);
      chk($sformatf("v%0d mem_pc", i), bus.mem_pc, t.e_pc);
      chk($sformatf("v%0d mem_wreg", i), 32'(bus.mem_wreg), 32'(t.e_wreg));
      chk($sformatf("v%0d mem_wen", i), 32'(bus.mem_wen), 32'(t.e_wen));
      chk($sformatf("v%0d mem_mem_op", i), 32'(bus.mem_mem_op), 32'(t.e_op));
      chk($sformatf("v%0d mem_store_data", i), bus.mem_store_data, t.e_sd);
    end
    if (t.e_xv) begin
      chk($sformatf("v%0d exc_epc", i), bus.exc_epc, t.e_pc);
      chk($sformatf("v%0d exc_wen_cleared", i), 32'(bus.mem_wen), 32'(t.e_wen));
      chk($sformatf("v%0d exc_mem_op_cleared", i), 32'(bus.mem_mem_op), 32'(t.e_op));
    end
    if (t.e_fv) begin
      chk($sformatf("v%0d fwd_reg", i), 32'(bus.fwd_reg), 32'(t.e_wreg));
      chk($sformatf("v%0d fwd_data", i), bus.fwd_data, t.e_res);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    //          v res            ov chk pc             wr wen op sd             mr ack fl  rdy mv e_res          e_pc           e_wr e_wen e_op e_sd          xv fv
    tv[0]  = '{1, 32'h1234,      0, 0, 32'h100,       5, 1, 0, 32'h0,         1, 0, 0,  1, 1, 32'h1234,      32'h100,       5, 1, 0, 32'h0,         0, 1};
    tv[1]  = '{1, 32'hAAAA,      0, 0, 32'h104,       6, 1, 0, 32'h55,        1, 0, 0,  1, 1, 32'hAAAA,      32'h104,       6, 1, 0, 32'h55,        0, 1};
    tv[2]  = '{1, 32'hBBBB,      0, 0, 32'h108,       7, 1, 0, 32'h0,         0, 0, 0,  0, 1, 32'hAAAA,      32'h104,       6, 1, 0, 32'h55,        0, 1};
    tv[3]  = '{1, 32'hBBBB,      0, 0, 32'h108,       7, 1, 0, 32'h0,         0, 0, 0,  0, 1, 32'hAAAA,      32'h104,       6, 1, 0, 32'h55,        0, 1};
    tv[4]  = '{1, 32'hBBBB,      0, 0, 32'h108,       7, 1, 0, 32'h0,         0, 0, 0,  0, 1, 32'hAAAA,      32'h104,       6, 1, 0, 32'h55,        0, 1};
    tv[5]  = '{1, 32'hBBBB,      0, 0, 32'h108,       7, 1, 0, 32'h0,         1, 0, 0,  1, 1, 32'hBBBB,      32'h108,       7, 1, 0, 32'h0,         0, 1};
    tv[6]  = '{0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 32'h0,         1, 0, 0,  1, 0, 32'h0,         32'h0,         0, 0, 0, 32'h0,         0, 0};
    tv[7]  = '{1, 32'h7FFFFFFF,  1, 1, 32'hBFC00100,  8, 1, 0, 32'h0,         1, 0, 0,  1, 0, 32'h0,         32'hBFC00100,  0, 0, 0, 32'h0,         1, 0};
    tv[8]  = '{1, 32'h1111,      0, 0, 32'h200,       9, 1, 0, 32'h0,         1, 0, 0,  0, 0, 32'h0,         32'hBFC00100,  0, 0, 0, 32'h0,         1, 0};
    tv[9]  = '{0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 32'h0,         1, 1, 0,  0, 0, 32'h0,         32'h0,         0, 0, 0, 32'h0,         0, 0};
    tv[10] = '{1, 32'h80000000,  1, 0, 32'h110,       9, 1, 0, 32'h0,         1, 0, 0,  1, 1, 32'h80000000,  32'h110,       9, 1, 0, 32'h0,         0, 1};
    tv[11] = '{0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 32'h0,         0, 1, 0,  0, 1, 32'h80000000,  32'h110,       9, 1, 0, 32'h0,         0, 1};
    tv[12] = '{1, 32'h2222,      0, 0, 32'h114,      10, 1, 0, 32'h0,         1, 0, 1,  1, 0, 32'h0,         32'h0,         0, 0, 0, 32'h0,         0, 0};
    tv[13] = '{0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 32'h0,         1, 0, 0,  1, 0, 32'h0,         32'h0,         0, 0, 0, 32'h0,         0, 0};
    tv[14] = '{1, 32'h3000,      0, 0, 32'h118,      11, 1, 1, 32'h0,         0, 0, 0,  1, 1, 32'h3000,      32'h118,      11, 1, 1, 32'h0,         0, 0};
    tv[15] = '{0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 32'h0,         0, 0, 0,  0, 1, 32'h3000,      32'h118,      11, 1, 1, 32'h0,         0, 0};
    tv[16] = '{1, 32'h4444,      0, 0, 32'h11C,       0, 1, 0, 32'h0,         1, 0, 0,  1, 1, 32'h4444,      32'h11C,       0, 1, 0, 32'h0,         0, 0};
    tv[17] = '{1, 32'h5000,      0, 0, 32'h120,       0, 0, 8, 32'hDEADBEEF,  1, 0, 0,  1, 1, 32'h5000,      32'h120,       0, 0, 8, 32'hDEADBEEF,  0, 0};
    tv[18] = '{1, 32'h1,         1, 1, 32'h124,       3, 1, 9, 32'h77,        1, 0, 0,  1, 0, 32'h0,         32'h124,       0, 0, 0, 32'h0,         1, 0};
    tv[19] = '{0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 32'h0,         1, 0, 1,  0, 0, 32'h0,         32'h0,         0, 0, 0, 32'h0,         0, 0};
    tv[20] = '{0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 32'h0,         1, 0, 0,  1, 0, 32'h0,         32'h0,         0, 0, 0, 32'h0,         0, 0};

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset state: nothing held, all data outputs cleared, ready to accept.
    chk("rst ex_ready", 32'(bus.ex_ready), 32'h1);
    chk("rst mem_valid", 32'(bus.mem_valid), 32'h0);
    chk("rst exc_valid", 32'(bus.exc_valid), 32'h0);
    chk("rst exc_code", 32'(bus.exc_code), 32'h0);
    chk("rst exc_epc", bus.exc_epc, 32'h0);
    chk("rst fwd_valid", 32'(bus.fwd_valid), 32'h0);
    chk("rst fwd_reg", 32'(bus.fwd_reg), 32'h0);
    chk("rst fwd_data", bus.fwd_data, 32'h0);
    chk("rst mem_alu_res", bus.mem_alu_res, 32'h0);
    chk("rst mem_pc", bus.mem_pc, 32'h0);
    chk("rst mem_wreg", 32'(bus.mem_wreg), 32'h0);
    chk("rst mem_wen", 32'(bus.mem_wen), 32'h0);
    chk("rst mem_mem_op", 32'(bus.mem_mem_op), 32'h0);
    chk("rst mem_store_data", bus.mem_store_data, 32'h0);

    reset = 1'b0;

    // Table: drive, check ex_ready before the edge, check outputs after it.
    for (int i = 0; i < NV; i++) begin
      drive(tv[i]);
      #1;
`ifndef EX_MEM_SKID_EN
      chk($sformatf("v%0d ex_ready", i), 32'(bus.ex_ready), 32'(tv[i].e_rdy));
`endif
      @(posedge clk);
      #1;
      check_outputs(i, tv[i]);
    end

    // Reset in the middle of a held transfer clears the entry with no edge.
    idle_inputs();
    bus.ex_valid   = 1'b1;
    bus.ex_alu_res = 32'hCAFE0001;
    bus.ex_pc      = 32'h300;
    bus.ex_wreg    = 5'd12;
    bus.ex_wen     = 1'b1;
    bus.mem_ready  = 1'b0;
    @(posedge clk);
    #1;
    bus.ex_valid = 1'b0;
    chk("mid_rst held mem_valid", 32'(bus.mem_valid), 32'h1);
    chk("mid_rst held fwd_data", bus.fwd_data, 32'hCAFE0001);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst mem_valid", 32'(bus.mem_valid), 32'h0);
    chk("mid_rst fwd_valid", 32'(bus.fwd_valid), 32'h0);
    chk("mid_rst mem_alu_res", bus.mem_alu_res, 32'h0);
    chk("mid_rst ex_ready", 32'(bus.ex_ready), 32'h1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst mem_valid", 32'(bus.mem_valid), 32'h0);
    chk("post_rst ex_ready", 32'(bus.ex_ready), 32'h1);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem_reg.md
# ex_mem_reg

EX/MEM pipeline stage register for the MIPS core, directly downstream of the ALU. It captures each executed instruction's ALU result, overflow flag and pass-through control, and turns a qualified overflow into a precise Ov exception toward CP0. It presents the instruction to the MEM stage over a valid/ready handshake and drives the EX-stage bypass path.

## Interface
Parameters:
- `EXC_OV`, default 5'h0C, exception code reported for arithmetic overflow.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `flush`  in  1  CP0 redirect; discards every held entry.
- `ex_valid`  in  1  EX offers an instruction.
- `ex_ready`  out  1  stage accepts the offered instruction this cycle.
- `ex_alu_res`  in  32  ALU result.
- `ex_alu_ov`  in  1  ALU overflow flag.
- `ex_ov_chk`  in  1  instruction traps on overflow (add, addi, sub).
- `ex_pc`  in  32  instruction PC.
- `ex_wreg`  in  5  destination register.
- `ex_wen`  in  1  register write enable.
- `ex_mem_op`  in  4  memory op code; 0 means none, 1..3 are loads, 8..15 are stores.
- `ex_store_data`  in  32  store data.
- `mem_valid`  out  1  head entry offered to MEM.
- `mem_ready`  in  1  MEM accepts the head entry.
- `mem_alu_res`, `mem_pc`, `mem_wreg`, `mem_wen`, `mem_mem_op`, `mem_store_data`  out  32/32/5/1/4/32  head entry fields.
- `exc_valid`  out  1  overflow exception pending.
- `exc_code`  out  5  equals `EXC_OV` while `exc_valid` is high, 0 otherwise.
- `exc_epc`  out  32  PC of the faulting instruction.
- `exc_ack`  in  1  CP0 has taken the exception.
- `fwd_valid`  out  1  bypass data is valid.
- `fwd_reg`  out  5  bypass destination register.
- `fwd_data`  out  32  bypass value.

## Operation
- A transfer in from EX occurs when `ex_valid` and `ex_ready` are both high. A transfer out to MEM occurs when `mem_valid` and `mem_ready` are both high.
- Each entry stores all `ex_*` fields plus an `exc` bit, set to `ex_alu_ov & ex_ov_chk`. A set `exc` bit forces the stored `wen` to 0 and `mem_op` to 0.
- The state machine has three states: EMPTY, FULL and EXC.
- EMPTY → FULL on a transfer in of a non-excepting instruction.
- EMPTY → EXC on a transfer in with `exc` set.
- FULL → EMPTY on a transfer out with no simultaneous transfer in.
- FULL → FULL on a simultaneous transfer out and transfer in; the new entry replaces the head.
- FULL → EXC when the transfer out coincides with a transfer in that has `exc` set.
- EXC → EMPTY on `exc_ack`.
- In EXC: `mem_valid`=0, `exc_valid`=1, `exc_epc`=entry PC, and `ex_ready`=0.
- `flush` forces EMPTY on the next edge. It overrides any transfer in, transfer out or `exc_ack` in the same cycle.
- `ex_ready` = EMPTY | (FULL & `mem_ready`). The registered-ready variant is described under Configuration.
- `fwd_valid` = FULL & head `wen` & head `mem_op`==0 & head `wreg`≠0. `fwd_data`=head `alu_res`. Load heads are never forwarded.
- All outputs are registered except `ex_ready` and the `fwd_*` decode.

## Timing
- Reset values: state EMPTY, `mem_valid`=0, `exc_valid`=0, `exc_code`=0, `fwd_valid`=0, and every data output 0. `ex_ready` is 1 after reset.
- Latency from transfer in to `mem_valid` is 1 cycle. `exc_valid` also rises 1 cycle after the faulting transfer in.
- Throughput is one instruction per cycle while `mem_ready` is held high.
- Head fields hold stable while `mem_valid` & !`mem_ready`.
- `exc_valid` stays high until the edge that samples `exc_ack` or `flush`. `exc_ack` is ignored outside EXC.
- Asserting `reset` mid-transfer discards the entry immediately, with no edge needed.

## Configuration
- `EX_MEM_SKID_EN` defined: adds a second, skid entry and registers `ex_ready`.
  - `ex_ready` = skid entry empty.
  - When the head is stalled, an incoming instruction goes to the skid entry. The skid entry moves to the head on the next transfer out.
  - A skid entry with `exc` set enters EXC only once it reaches the head.
  - `ex_ready` is 0 while any held entry has `exc` set.
  - `flush` clears both entries.
- `EX_MEM_SKID_EN` undefined: single entry; `ex_ready` depends combinationally on `mem_ready` as described above.

## Test plan
- Reset with `reset`=1, then release. Send `ex_alu_res`=32'h0000_1234, `wreg`=5, `wen`=1, `mem_ready`=1. Expect `mem_valid`=1 next cycle with `mem_alu_res`=32'h1234, and `fwd_valid`=1 with `fwd_reg`=5.
- Hold `mem_ready`=0 for 3 cycles with a held entry. Expect the outputs stable and `ex_ready`=0; with skid enabled, a second instruction is accepted and `ex_ready` drops to 0 afterwards.
- Send `ex_alu_ov`=1, `ex_ov_chk`=1, `pc`=32'hBFC0_0100. Expect `exc_valid`=1, `exc_code`=5'h0C, `exc_epc`=32'hBFC0_0100, `mem_valid`=0. Pulse `exc_ack`; expect EMPTY and `ex_ready`=1.
- Send `ex_alu_ov`=1 with `ex_ov_chk`=0 (addu). Expect a normal pass-through and `exc_valid` to stay 0.
- Assert `flush` together with `ex_valid`=1 in the FULL state. Expect `mem_valid`=0 next cycle and the new instruction dropped.
- Hold a load head (`mem_op`=1, `wen`=1). Expect `fwd_valid`=0. Hold a head with `wreg`=0 and `wen`=1. Expect `fwd_valid`=0.
